// File: rtl/panda_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional single-cycle special-case path: define PANDA_DIV_EARLY_OUT_EN.
module panda_divider #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic             flush_i,
    output logic             valid_o,
    output logic [Width-1:0] result_o
);

    localparam int CntW = $clog2(Width);
    localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic             sa_q;
    logic             sb_q;
    logic             bzero_q;
    logic [Width-1:0] bmag_q;
    logic [Width:0]   rem_q;
    logic [Width-1:0] quo_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] result_q;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [Width-1:0] amag;
    logic [Width-1:0] bmag;
    logic [Width+1:0] shifted;
    logic [Width+1:0] trial;
    logic [Width:0]   rem_d;
    logic [Width-1:0] quo_d;
    logic [Width-1:0] quo_fix;
    logic [Width-1:0] rem_fix;

    assign signed_op = ~op_i[0];
    assign a_neg     = signed_op & operand_a_i[Width-1];
    assign b_neg     = signed_op & operand_b_i[Width-1];
    assign amag      = a_neg ? -operand_a_i : operand_a_i;
    assign bmag      = b_neg ? -operand_b_i : operand_b_i;

    // Shifted remainder stays below 2^(Width+1), so bit Width+1 of trial is the borrow.
    assign shifted = {rem_q, quo_q[Width-1]};
    assign trial   = shifted - {2'b00, bmag_q};

    always_comb begin
        rem_d = shifted[Width:0];
        quo_d = {quo_q[Width-2:0], 1'b0};
        if (!trial[Width+1]) begin
            rem_d    = trial[Width:0];
            quo_d[0] = 1'b1;
        end
    end

    assign quo_fix = ((sa_q ^ sb_q) & ~bzero_q) ? -quo_q : quo_q;
    assign rem_fix = sa_q ? -rem_q[Width-1:0] : rem_q[Width-1:0];

`ifdef PANDA_DIV_EARLY_OUT_EN
    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

    logic             eo_zero;
    logic             eo_ovf;
    logic [Width-1:0] eo_res;

    assign eo_zero = (operand_b_i == '0);
    assign eo_ovf  = signed_op & (operand_a_i == MinVal) & (&operand_b_i);

    always_comb begin
        eo_res = eo_zero ? '1 : MinVal;
        if (op_i[1]) begin
            eo_res = eo_zero ? operand_a_i : '0;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bzero_q  <= 1'b0;
            bmag_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q    <= op_i;
                        sa_q    <= a_neg;
                        sb_q    <= b_neg;
                        bzero_q <= (operand_b_i == '0);
                        bmag_q  <= bmag;
                        rem_q   <= '0;
                        quo_q   <= amag;
                        cnt_q   <= CntLast;
`ifdef PANDA_DIV_EARLY_OUT_EN
                        if (eo_zero | eo_ovf) begin
                            result_q <= eo_res;
                            state_q  <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
`else
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    result_q <= op_q[1] ? rem_fix : quo_fix;
                    state_q  <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE) & ~flush_i;
    assign valid_o  = (state_q == DONE) & ~flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_panda_divider.sv
// Scoreboard bench for panda_divider: random and directed RV32M divides.
// Expected values come from plain SV arithmetic with RISC-V special cases.
module tb_panda_divider;

    localparam int W = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [1:0]    op_i = 2'd0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  result_o;

    panda_divider #(.Width(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .operand_a_i(a_i),
        .operand_b_i(b_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] last_res = '0;
    bit          rdy_chk = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        bit ovf;
        sa  = a;
        sb  = b;
        ovf = (a == MIN) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return MIN;
                return sa / sb;
            end
            2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef PANDA_DIV_EARLY_OUT_EN
        if (b == 0) return 1;
        if (!op[0] && a == MIN && b == 32'hFFFF_FFFF) return 1;
`else
        if (op == 2'd3 && a == 0 && b == 0) return W + 1;
`endif
        return W + 1;
    endfunction

    // Monitor: pops the scoreboard on each completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni) begin
            if (rdy_chk) begin
                rdy_chk = 1'b0;
                check("ready_after_done", 32'(ready_o), 32'd1);
            end
            if (valid_o) begin
                check("ready_low_with_valid", 32'(ready_o), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_valid: got result %h, required no pulse",
                             result_o);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_result"}, result_o, e.res);
                    check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                    last_res = e.res;
                    rdy_chk  = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string nm,
                         input bit track);
        bit   got;
        exp_t e;
        got = 1'b0;
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (ready_o) got = 1'b1;
        end
        if (!got) begin
            checks++;
            $display("FAIL %s_accept: got ready_o 0 for 200 cycles, required 1", nm);
            valid_i = 1'b0;
            return;
        end
        if (track) begin
            e.res  = ref_model(op, a, b);
            e.acc  = cyc + 1;
            e.lat  = ref_lat(op, a, b);
            e.name = nm;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL %s_timeout: got %0d pending results, required 0",
                     nm, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string nm);
        issue(op, a, b, nm, 1'b1);
        wait_done(nm);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp[0] = 32'd0;
        sp[1] = 32'd1;
        sp[2] = 32'hFFFF_FFFF;
        sp[3] = MIN;
        sp[4] = 32'd7;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 1000));
        return $urandom;
    endfunction

    initial begin
        #2;
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        run(2'd1, 32'd100, 32'd7, "divu_100_7");
        run(2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run(2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run(2'd3, 32'hFFFF_FFF9, 32'd2, "remu_big_2");
        run(2'd0, 32'hFFFF_FFF9, 32'd0, "div_by0");
        run(2'd2, 32'hFFFF_FFF9, 32'd0, "rem_by0");
        run(2'd1, 32'd1234, 32'd0, "divu_by0");
        run(2'd3, 32'd1234, 32'd0, "remu_by0");
        run(2'd0, MIN, 32'hFFFF_FFFF, "div_ovf");
        run(2'd2, MIN, 32'hFFFF_FFFF, "rem_ovf");
        run(2'd1, MIN, 32'hFFFF_FFFF, "divu_min_all1");

        // Flush ten cycles into an operation.
        issue(2'd1, 32'd1000, 32'd3, "flush_op", 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_ready", 32'(ready_o), 32'd1);
        check("flush_result_held", result_o, last_res);
        repeat (40) @(negedge clk);
        run(2'd1, 32'd9, 32'd4, "divu_after_flush");

        // Asynchronous reset mid-operation.
        issue(2'd0, 32'd12345, 32'd77, "reset_op", 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        check("midreset_valid", 32'(valid_o), 32'd0);
        check("midreset_ready", 32'(ready_o), 32'd1);
        check("midreset_result", result_o, 32'd0);
        last_res = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (40) @(negedge clk);
        run(2'd3, 32'd10, 32'd3, "remu_after_reset");

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run(op, a, b, $sformatf("rand%0d_op%0d", i, op));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
